debug_loader_unit: RTL and testbench
====================================

Name: debug_loader_unit

Overview:
- Host-side controller for the MIPS pipeline: the writer that feeds `i_we_IF`/`i_instruction_data`/`i_halt` and the reader of the pipeline's WB/MEM debug outputs.
- Consumes UART RX bytes, assembles 32-bit instruction words and writes them into the IF instruction memory.
- Gates pipeline execution (continuous run or single step).
- Serializes a snapshot of pipeline state back to the host over UART TX.
- Sits between the UART core and the pipeline top at the board top level.

Parameters:
- NB_DATA, 32, pipeline data/instruction width
- NB_BYTE, 8, UART byte width
- NB_ADDR, 5, register address width
- NB_DADDR, 8, data-memory debug address width

Ports:
- clk  in  1  system clock
- i_rst  in  1  synchronous reset, active-high
- i_rx_data  in  8  received UART byte
- i_rx_valid  in  1  one-cycle pulse, i_rx_data valid
- o_tx_data  out  8  byte to transmit
- o_tx_start  out  1  one-cycle pulse, start TX of o_tx_data
- i_tx_done  in  1  one-cycle pulse, TX byte finished
- o_we_IF  out  1  one-cycle instruction-memory write strobe
- o_instruction_data  out  32  instruction word to write
- o_halt  out  1  1 = pipeline frozen
- i_program_end  in  1  pipeline reached end of program
- i_write_data_wb  in  32  WB write data
- i_reg2write_wb  in  5  WB destination register
- i_write_enable_wb  in  1  WB register write enable
- i_data2mem  in  32  MEM store data
- i_data_addr  in  8  MEM data address
- o_busy  out  1  1 when not in IDLE

Behaviour:
- Reset (i_rst=1 at posedge):
  - state=IDLE, o_halt=1, o_we_IF=0, o_tx_start=0.
  - o_tx_data=0, o_instruction_data=0, o_busy=0.
  - Word count, byte counter and snapshot latch all cleared.
- Reset mid-operation aborts any load, run or transmit immediately. A partially assembled word is discarded, never written.
- Commands (accepted only in IDLE): 0x4C 'L' load, 0x43 'C' continuous run, 0x53 'S' single step. All other bytes in IDLE are ignored.
- IDLE, byte 'L' -> LOAD_CNT.
- LOAD_CNT: the next rx byte is N, the word count.
  - N=0 -> IDLE, no write.
  - Otherwise -> LOAD_WORD with byte_cnt=0.
- LOAD_WORD: bytes arrive MSB first and shift into the assembly register.
  - On the 4th byte, the next cycle drives o_instruction_data=word and pulses o_we_IF=1 for exactly one cycle.
  - N is then decremented. At N=0 -> IDLE, otherwise collect the next word.
  - o_halt stays 1 throughout loading.
- IDLE, byte 'C' -> RUN: o_halt=0 from the next cycle.
- RUN ends on i_program_end=1, or on rx byte 0x48 'H' (manual break):
  - o_halt=1 on the following cycle.
  - The snapshot is latched in that same cycle.
  - -> SEND.
  - All other rx bytes in RUN are ignored.
- IDLE, byte 'S' -> STEP:
  - o_halt=0 for exactly one cycle, then 1.
  - The snapshot is latched on the cycle o_halt returns to 1.
  - -> SEND.
- Snapshot content, 16 bytes sent MSB first, word order:
  - W0 = i_write_data_wb.
  - W1 = {26'b0, i_write_enable_wb, i_reg2write_wb}.
  - W2 = i_data2mem.
  - W3 = {24'b0, i_data_addr}.
  - Bytes are transmitted from the latch, so later pipeline activity does not affect them.
- SEND/SEND_WAIT handshake:
  - SEND drives o_tx_data=byte[k] and pulses o_tx_start for one cycle, then enters SEND_WAIT.
  - SEND_WAIT holds o_tx_data until i_tx_done. On i_tx_done, k increments; if k=16 -> IDLE, else -> SEND.
  - Never more than one outstanding o_tx_start.
  - i_tx_done outside SEND_WAIT is ignored.
- rx bytes in SEND/SEND_WAIT are dropped.
- Simultaneous events:
  - i_program_end and 'H' in the same cycle are treated as one stop.
  - If i_program_end is high when 'C' is received, the run lasts exactly one cycle (o_halt=0 once), then stops and sends the snapshot.
- o_busy = (state != IDLE).

Decomposition:
- Package debug_pkg:
  - command byte constants CMD_LOAD, CMD_RUN, CMD_STEP, CMD_BREAK.
  - state encoding: IDLE, LOAD_CNT, LOAD_WORD, RUN, STEP, SEND, SEND_WAIT.
  - SNAP_BYTES=16.
- One sub-module, debug_tx_serializer:
  - holds the 128-bit snapshot latch and byte index.
  - implements the SEND/SEND_WAIT handshake.
  - controlled by load and start inputs, reports done.
- Command/load FSM lives in the top module.

Test Plan:
- Reset with random inputs -> o_halt=1, o_we_IF=0, o_tx_start=0, o_busy=0.
- Send 'L', 0x02, bytes 20 01 00 05 8C 02 00 04 -> exactly two o_we_IF pulses, with data 0x20010005 then 0x8C020004; return to IDLE; o_halt=1 throughout.
- Send 'L', 0x00 -> no o_we_IF pulse, IDLE next cycle. Send 'L', 0x01, 2 bytes, then assert i_rst -> no write; a subsequent 'L' load works.
- Send 'S' with i_write_data_wb=0xDEADBEEF, reg=5, we=1, data2mem=0x12345678, addr=0x10 -> o_halt low exactly 1 cycle; TX bytes DE AD BE EF 00 00 00 25 12 34 56 78 00 00 00 10 with one o_tx_start per i_tx_done.
- Send 'C', hold 50 cycles, raise i_program_end -> o_halt=1 next cycle; 16-byte snapshot sent. Repeat with 'H' instead of i_program_end -> same behaviour.
- During SEND, inject rx 'C' and spurious i_tx_done in SEND state -> byte ignored, no extra o_tx_start, exactly 16 bytes sent.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared definitions for the debug loader: host command bytes, controller
// state encoding and the snapshot size.
package debug_pkg;

    localparam logic [7:0] CMD_LOAD  = 8'h4C;  // 'L'
    localparam logic [7:0] CMD_RUN   = 8'h43;  // 'C'
    localparam logic [7:0] CMD_STEP  = 8'h53;  // 'S'
    localparam logic [7:0] CMD_BREAK = 8'h48;  // 'H'

    localparam int SNAP_BYTES = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_CNT,
        LOAD_WORD,
        RUN,
        STEP,
        SEND,
        SEND_WAIT
    } state_e;

endpackage

// File: rtl/debug_tx_serializer.sv
// Latches a pipeline snapshot and streams it MSB first to the UART transmitter,
// keeping at most one byte in flight.
module debug_tx_serializer
    import debug_pkg::*;
#(
    parameter int NB_BYTE = 8,
    parameter int NB_SNAP = SNAP_BYTES * NB_BYTE
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic               i_start,
    input  logic [NB_SNAP-1:0] i_snapshot,
    input  logic               i_tx_done,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_done
);

    localparam int IDX_W = $clog2(SNAP_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SNAP_BYTES - 1);

    state_e             phase_q, phase_d;
    logic [NB_SNAP-1:0] snap_q, snap_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NB_BYTE-1:0] tx_data_q, tx_data_d;
    logic               tx_start_q, tx_start_d;

    always_comb begin
        phase_d    = phase_q;
        snap_d     = snap_q;
        idx_d      = idx_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        o_done     = 1'b0;

        case (phase_q)
            SEND: begin
                // The latch shifts left, so the next byte is always at the top.
                tx_data_d  = snap_q[NB_SNAP-1 -: NB_BYTE];
                snap_d     = snap_q << NB_BYTE;
                tx_start_d = 1'b1;
                phase_d    = SEND_WAIT;
            end
            SEND_WAIT: begin
                if (i_tx_done) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        phase_d = IDLE;
                        o_done  = 1'b1;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        phase_d = SEND;
                    end
                end
            end
            default: ;
        endcase

        if (i_load) begin
            snap_d = i_snapshot;
        end
        if (i_start) begin
            idx_d   = '0;
            phase_d = SEND;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            phase_q    <= IDLE;
            snap_q     <= '0;
            idx_q      <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            snap_q     <= snap_d;
            idx_q      <= idx_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
        end
    end

    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;

endmodule

// File: rtl/debug_loader_unit.sv
// Host-side debug controller: loads instruction memory from UART, gates the
// pipeline (run / single step) and returns a state snapshot over UART.
module debug_loader_unit
    import debug_pkg::*;
#(
    parameter int NB_DATA  = 32,
    parameter int NB_BYTE  = 8,
    parameter int NB_ADDR  = 5,
    parameter int NB_DADDR = 8
) (
    input  logic                clk,
    input  logic                i_rst,
    input  logic [NB_BYTE-1:0]  i_rx_data,
    input  logic                i_rx_valid,
    output logic [NB_BYTE-1:0]  o_tx_data,
    output logic                o_tx_start,
    input  logic                i_tx_done,
    output logic                o_we_IF,
    output logic [NB_DATA-1:0]  o_instruction_data,
    output logic                o_halt,
    input  logic                i_program_end,
    input  logic [NB_DATA-1:0]  i_write_data_wb,
    input  logic [NB_ADDR-1:0]  i_reg2write_wb,
    input  logic                i_write_enable_wb,
    input  logic [NB_DATA-1:0]  i_data2mem,
    input  logic [NB_DADDR-1:0] i_data_addr,
    output logic                o_busy
);

    localparam int NB_SNAP = 4 * NB_DATA;

    state_e             state_q, state_d;
    logic               halt_q, halt_d;
    logic               we_q, we_d;
    logic [NB_DATA-1:0] instr_q, instr_d;
    logic [NB_DATA-1:0] asm_q, asm_d;
    logic [NB_BYTE-1:0] word_cnt_q, word_cnt_d;
    logic [1:0]         byte_cnt_q, byte_cnt_d;
    logic               snap_load;
    logic               snap_start;
    logic               ser_done;
    logic [NB_SNAP-1:0] snapshot;

    assign snapshot = {
        i_write_data_wb,
        {(NB_DATA - NB_ADDR - 1){1'b0}}, i_write_enable_wb, i_reg2write_wb,
        i_data2mem,
        {(NB_DATA - NB_DADDR){1'b0}}, i_data_addr
    };

    always_comb begin
        state_d    = state_q;
        halt_d     = halt_q;
        we_d       = 1'b0;
        instr_d    = instr_q;
        asm_d      = asm_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        snap_load  = 1'b0;
        snap_start = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_rx_valid) begin
                    case (i_rx_data)
                        CMD_LOAD: state_d = LOAD_CNT;
                        CMD_RUN: begin
                            state_d = RUN;
                            halt_d  = 1'b0;
                        end
                        CMD_STEP: begin
                            state_d = STEP;
                            halt_d  = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            LOAD_CNT: begin
                if (i_rx_valid) begin
                    word_cnt_d = i_rx_data;
                    byte_cnt_d = 2'd0;
                    state_d    = (i_rx_data == '0) ? IDLE : LOAD_WORD;
                end
            end
            LOAD_WORD: begin
                if (i_rx_valid) begin
                    asm_d      = {asm_q[NB_DATA-NB_BYTE-1:0], i_rx_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        instr_d    = asm_d;
                        we_d       = 1'b1;
                        word_cnt_d = word_cnt_q - 1'b1;
                        if (word_cnt_q == NB_BYTE'(1)) begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            RUN: begin
                // Program end and a manual break landing together are one stop.
                if (i_program_end || (i_rx_valid && i_rx_data == CMD_BREAK)) begin
                    halt_d     = 1'b1;
                    snap_load  = 1'b1;
                    snap_start = 1'b1;
                    state_d    = SEND;
                end
            end
            STEP: begin
                halt_d     = 1'b1;
                snap_load  = 1'b1;
                snap_start = 1'b1;
                state_d    = SEND;
            end
            SEND, SEND_WAIT: begin
                if (ser_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            halt_q     <= 1'b1;
            we_q       <= 1'b0;
            instr_q    <= '0;
            asm_q      <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            halt_q     <= halt_d;
            we_q       <= we_d;
            instr_q    <= instr_d;
            asm_q      <= asm_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    debug_tx_serializer #(
        .NB_BYTE (NB_BYTE),
        .NB_SNAP (NB_SNAP)
    ) u_tx_serializer (
        .clk        (clk),
        .i_rst      (i_rst),
        .i_load     (snap_load),
        .i_start    (snap_start),
        .i_snapshot (snapshot),
        .i_tx_done  (i_tx_done),
        .o_tx_data  (o_tx_data),
        .o_tx_start (o_tx_start),
        .o_done     (ser_done)
    );

    assign o_we_IF            = we_q;
    assign o_instruction_data = instr_q;
    assign o_halt             = halt_q;
    assign o_busy             = (state_q != IDLE);

endmodule

// File: tb/tb_debug_loader_unit.sv
// Directed bench for debug_loader_unit with a small UART TX responder model.
module tb_debug_loader_unit;

    logic        clk = 1'b0;
    logic        i_rst;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic        i_tx_done;
    logic        o_we_IF;
    logic [31:0] o_instruction_data;
    logic        o_halt;
    logic        i_program_end;
    logic [31:0] i_write_data_wb;
    logic [4:0]  i_reg2write_wb;
    logic        i_write_enable_wb;
    logic [31:0] i_data2mem;
    logic [7:0]  i_data_addr;
    logic        o_busy;

    always #5 clk = ~clk;

    debug_loader_unit dut (
        .clk                (clk),
        .i_rst              (i_rst),
        .i_rx_data          (i_rx_data),
        .i_rx_valid         (i_rx_valid),
        .o_tx_data          (o_tx_data),
        .o_tx_start         (o_tx_start),
        .i_tx_done          (i_tx_done),
        .o_we_IF            (o_we_IF),
        .o_instruction_data (o_instruction_data),
        .o_halt             (o_halt),
        .i_program_end      (i_program_end),
        .i_write_data_wb    (i_write_data_wb),
        .i_reg2write_wb     (i_reg2write_wb),
        .i_write_enable_wb  (i_write_enable_wb),
        .i_data2mem         (i_data2mem),
        .i_data_addr        (i_data_addr),
        .o_busy             (o_busy)
    );

    int tests = 0;
    int fails = 0;

    // Monitor state (written only by the negedge monitor)
    int          we_n = 0;
    logic [31:0] we_words [0:15];
    int          tx_n = 0;
    logic [7:0]  tx_bytes [0:127];
    int          halt_low_n = 0;
    int          overlap_n = 0;

    // Responder state (written only by the responder)
    int done_n = 0;
    int wait_c = 0;
    int hold_left = 0;
    bit dbl = 1'b0;

    always @(negedge clk) begin
        if (o_we_IF) begin
            if (we_n < 16) we_words[we_n] = o_instruction_data;
            we_n++;
        end
        if (!o_halt) halt_low_n++;
        if (o_tx_start) begin
            if (tx_n > done_n) overlap_n++;
            if (tx_n < 128) tx_bytes[tx_n] = o_tx_data;
            tx_n++;
        end
    end

    // UART TX model: answers each start with a done a few cycles later; with
    // dbl set the done is held an extra cycle to land on the SEND cycle.
    initial begin
        i_tx_done = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (hold_left > 0) begin
                hold_left--;
            end else if (i_tx_done) begin
                i_tx_done = 1'b0;
            end else if (tx_n > done_n) begin
                if (wait_c == 3) begin
                    wait_c    = 0;
                    i_tx_done = 1'b1;
                    done_n++;
                    hold_left = dbl ? 1 : 0;
                end else begin
                    wait_c++;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        tick();
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (o_busy && n < 600) begin
            tick();
            n++;
        end
        check(tag, {127'b0, o_busy}, 128'd0);
    endtask

    task automatic check_snap(input string tag, input int base, input logic [127:0] exp);
        logic [127:0] got;
        got = '0;
        check({tag, "_count"}, 128'(tx_n - base), 128'd16);
        for (int k = 0; k < 16; k++) begin
            if (base + k < 128) got = {got[119:0], tx_bytes[base + k]};
        end
        check({tag, "_bytes"}, got, exp);
    endtask

    task automatic garble_pipeline();
        i_write_data_wb   = 32'h5555AAAA;
        i_reg2write_wb    = 5'd9;
        i_write_enable_wb = 1'b0;
        i_data2mem        = 32'h0F0F0F0F;
        i_data_addr       = 8'hEE;
    endtask

    initial begin
        int we0, tx0, hl0;

        i_rst = 1'b1;
        i_rx_data = 8'h00;
        i_rx_valid = 1'b0;
        i_program_end = 1'b0;
        i_write_data_wb = '0;
        i_reg2write_wb = '0;
        i_write_enable_wb = 1'b0;
        i_data2mem = '0;
        i_data_addr = '0;

        // Reset with random activity on the inputs
        repeat (3) begin
            i_rx_data         = 8'($urandom);
            i_rx_valid        = 1'($urandom);
            i_program_end     = 1'($urandom);
            i_write_data_wb   = $urandom;
            i_reg2write_wb    = 5'($urandom);
            i_write_enable_wb = 1'($urandom);
            i_data2mem        = $urandom;
            i_data_addr       = 8'($urandom);
            tick();
        end
        check("rst_halt", {127'b0, o_halt}, 128'd1);
        check("rst_we", {127'b0, o_we_IF}, 128'd0);
        check("rst_tx_start", {127'b0, o_tx_start}, 128'd0);
        check("rst_busy", {127'b0, o_busy}, 128'd0);
        check("rst_tx_data", {120'b0, o_tx_data}, 128'd0);
        check("rst_instr", {96'b0, o_instruction_data}, 128'd0);
        i_rx_valid = 1'b0;
        i_rx_data = 8'h00;
        i_program_end = 1'b0;
        i_rst = 1'b0;
        tick();

        // Two-word load
        we0 = we_n;
        hl0 = halt_low_n;
        send_byte(8'h4C);
        check("load_busy", {127'b0, o_busy}, 128'd1);
        send_byte(8'h02);
        send_byte(8'h20); send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
        send_byte(8'h8C); send_byte(8'h02); send_byte(8'h00); send_byte(8'h04);
        check("load_idle", {127'b0, o_busy}, 128'd0);
        tick();
        tick();
        check("load_we_count", 128'(we_n - we0), 128'd2);
        check("load_word0", {96'b0, we_words[we0]}, 128'h20010005);
        check("load_word1", {96'b0, we_words[we0 + 1]}, 128'h8C020004);
        check("load_halt_held", 128'(halt_low_n - hl0), 128'd0);

        // Zero-length load
        we0 = we_n;
        send_byte(8'h4C);
        send_byte(8'h00);
        check("load0_idle", {127'b0, o_busy}, 128'd0);
        tick();
        check("load0_no_we", 128'(we_n - we0), 128'd0);

        // Reset in the middle of a word, then a clean load
        we0 = we_n;
        send_byte(8'h4C);
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h22);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        tick();
        check("abort_idle", {127'b0, o_busy}, 128'd0);
        check("abort_no_we", 128'(we_n - we0), 128'd0);
        send_byte(8'h4C);
        send_byte(8'h01);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        tick();
        check("reload_we_count", 128'(we_n - we0), 128'd1);
        check("reload_word", {96'b0, we_words[we0]}, 128'hAABBCCDD);

        // Single step
        i_write_data_wb   = 32'hDEADBEEF;
        i_reg2write_wb    = 5'd5;
        i_write_enable_wb = 1'b1;
        i_data2mem        = 32'h12345678;
        i_data_addr       = 8'h10;
        hl0 = halt_low_n;
        tx0 = tx_n;
        send_byte(8'h53);
        check("step_halt_low", {127'b0, o_halt}, 128'd0);
        tick();
        check("step_halt_back", {127'b0, o_halt}, 128'd1);
        garble_pipeline();
        wait_idle("step_send_timeout");
        check("step_halt_cycles", 128'(halt_low_n - hl0), 128'd1);
        check_snap("step_snap", tx0, 128'hDEADBEEF_00000025_12345678_00000010);

        // Continuous run stopped by program end
        i_write_data_wb   = 32'h01234567;
        i_reg2write_wb    = 5'd31;
        i_write_enable_wb = 1'b0;
        i_data2mem        = 32'hCAFEF00D;
        i_data_addr       = 8'hFF;
        tx0 = tx_n;
        send_byte(8'h43);
        check("run_halt_low", {127'b0, o_halt}, 128'd0);
        send_byte(8'h4C);
        repeat (49) tick();
        check("run_still_running", {126'b0, o_halt, o_busy}, 128'd1);
        i_program_end = 1'b1;
        tick();
        check("run_end_halt", {127'b0, o_halt}, 128'd1);
        i_program_end = 1'b0;
        garble_pipeline();
        wait_idle("run_send_timeout");
        check_snap("run_snap", tx0, 128'h01234567_0000001F_CAFEF00D_000000FF);

        // Continuous run stopped by 'H', with rx traffic and doubled done during send
        i_write_data_wb   = 32'hA5A5A5A5;
        i_reg2write_wb    = 5'd0;
        i_write_enable_wb = 1'b1;
        i_data2mem        = 32'h00000000;
        i_data_addr       = 8'h01;
        tx0 = tx_n;
        send_byte(8'h43);
        repeat (20) tick();
        send_byte(8'h48);
        check("brk_halt", {127'b0, o_halt}, 128'd1);
        check("brk_busy", {127'b0, o_busy}, 128'd1);
        dbl = 1'b1;
        garble_pipeline();
        tick();
        send_byte(8'h43);
        wait_idle("brk_send_timeout");
        dbl = 1'b0;
        check_snap("brk_snap", tx0, 128'hA5A5A5A5_00000020_00000000_00000001);
        tick();
        tick();
        check("brk_rx_dropped", {126'b0, o_halt, o_busy}, 128'd2);

        // Program end already high when 'C' arrives
        hl0 = halt_low_n;
        tx0 = tx_n;
        i_program_end = 1'b1;
        send_byte(8'h43);
        check("sim_halt_low", {127'b0, o_halt}, 128'd0);
        tick();
        check("sim_halt_back", {127'b0, o_halt}, 128'd1);
        i_program_end = 1'b0;
        wait_idle("sim_send_timeout");
        check("sim_halt_cycles", 128'(halt_low_n - hl0), 128'd1);
        check("sim_tx_count", 128'(tx_n - tx0), 128'd16);

        check("tx_no_overlap", 128'(overlap_n), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
